seq_detector_param: RTL and testbench

- Runtime-programmable serial bit-pattern detector with Mealy output. It is the parametrised successor of the fixed three-bit detector.
- Pattern value, pattern length (1..MAX_LEN) and overlap mode are loaded through a config port.
- Sits on a serial input stream qualified by a valid strobe. Flags every completed pattern in the same cycle as its last bit.

---
 rtl/seq_det_pkg.sv | 19 +
 rtl/seq_det_match.sv | 35 +++
 rtl/seq_detector_param.sv | 135 +++++++++++++
 tb/tb_seq_detector_param.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the runtime-programmable serial pattern detector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_det_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic {
        DISARMED = 1'b0,
        ARMED    = 1'b1
    } seq_det_state_t;

    // Wide enough for any legal length (up to 32) so (1<<len) never overflows.
    function automatic logic [63:0] len_to_mask(input logic [7:0] len);
        return (64'd1 << len) - 64'd1;
    endfunction

endpackage

// File: rtl/seq_det_match.sv
// Masked comparator: raw match of the newest len window bits against the pattern.
// Latency: purely combinational.
// Backpressure: none; caller qualifies the result with valid/state.
module seq_det_match
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic [MAX_LEN-1:0] window_i,
    input  logic [MAX_LEN-1:0] pattern_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic [LEN_W-1:0]   fill_i,
    output logic               raw_match_o
);

    logic [63:0]  mask;
    logic [63:0]  window_ext;
    logic [63:0]  pattern_ext;
    logic [LEN_W:0] have_bits;
    logic [LEN_W:0] need_bits;
    logic         enough;

    always_comb begin
        mask        = len_to_mask(8'(len_i));
        window_ext  = 64'(window_i);
        pattern_ext = 64'(pattern_i);
        // fill history bits plus the bit on x must cover the whole pattern
        have_bits   = {1'b0, fill_i} + (LEN_W + 1)'(1);
        need_bits   = {1'b0, len_i};
        enough      = (len_i != '0) && (have_bits >= need_bits);
        raw_match_o = enough && ((window_ext & mask) == (pattern_ext & mask));
    end

endmodule

// File: rtl/seq_detector_param.sv
// Programmable serial bit-pattern detector, Mealy y; optional counter via SEQ_DET_MATCH_CNT_EN.
// Latency: y in the same cycle as the final bit; armed/cfg_err one cycle after cfg_load.
// Backpressure: none; x is consumed whenever x_valid is high, cfg_load takes priority.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               x,
    input  logic               x_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               y,
    output logic               armed,
    output logic               cfg_err
`ifdef SEQ_DET_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]   match_count
`endif
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

    seq_det_state_t     state_q, state_d;
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               cfg_err_q, cfg_err_d;

    logic [MAX_LEN-1:0] window;
    logic               raw_match;
    logic               cfg_legal;

    assign window    = {hist_q, x};
    assign cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_MAX);

    seq_det_match #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_match (
        .window_i    (window),
        .pattern_i   (pat_q),
        .len_i       (len_q),
        .fill_i      (fill_q),
        .raw_match_o (raw_match)
    );

    assign y       = (state_q == ARMED) && x_valid && !cfg_load && raw_match;
    assign armed   = (state_q == ARMED);
    assign cfg_err = cfg_err_q;

    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        cfg_err_d = 1'b0;
        if (cfg_load) begin
            // Any load, legal or not, restarts the history; the bit on x is dropped.
            hist_d    = '0;
            fill_d    = '0;
            cfg_err_d = !cfg_legal;
            if (cfg_legal) begin
                state_d = ARMED;
                pat_d   = cfg_pattern;
                len_d   = cfg_len;
                ovl_d   = cfg_overlap;
            end else begin
                state_d = DISARMED;
            end
        end else if ((state_q == ARMED) && x_valid) begin
            hist_d = window[MAX_LEN-2:0];
            if (y && !ovl_q) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= DISARMED;
            hist_q    <= '0;
            fill_q    <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            ovl_q     <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            cfg_err_q <= cfg_err_d;
        end
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cfg_load) begin
            cnt_d = '0;
        end else if (y && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_count = cnt_q;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboarded bench for seq_detector_param: a bit-queue reference model predicts each cycle,
// a negedge monitor compares y/armed/cfg_err (and match_count when SEQ_DET_MATCH_CNT_EN is set).
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               x;
    logic               x_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               y;
    logic               armed;
    logic               cfg_err;
`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0]   match_count;
`endif

    always #5 clk = ~clk;

    seq_detector_param #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .x           (x),
        .x_valid     (x_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap)
        ,
        .y           (y),
        .armed       (armed),
        .cfg_err     (cfg_err)
`ifdef SEQ_DET_MATCH_CNT_EN
        ,
        .match_count (match_count)
`endif
    );

    typedef struct {
        bit y;
        bit armed;
        bit err;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   hits  = 0;

    // Reference model: the valid bits seen since the last restart, plus the loaded config.
    bit       m_armed;
    bit [7:0] m_pat;
    int       m_len;
    bit       m_ovl;
    bit       m_hist[$];
    bit       m_err;
    int       m_cnt;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_armed = 0;
        m_pat   = '0;
        m_len   = 0;
        m_ovl   = 0;
        m_hist.delete();
        m_err   = 0;
        m_cnt   = 0;
    endfunction

    function automatic bit model_y(input bit load, input bit vld, input bit xb);
        bit w[$];
        if (!m_armed || !vld || load) return 1'b0;
        if (m_hist.size() + 1 < m_len) return 1'b0;
        w = m_hist;
        w.push_back(xb);
        for (int i = 0; i < m_len; i++) begin
            if (w[w.size() - 1 - i] != m_pat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic step(input bit load, input bit [7:0] pat, input int len,
                        input bit ovl, input bit vld, input bit xb);
        exp_t e;
        bit   yy;
        @(posedge clk);
        #1;
        cfg_load    = load;
        cfg_pattern = pat;
        cfg_len     = LEN_W'(len);
        cfg_overlap = ovl;
        x_valid     = vld;
        x           = xb;
        yy      = model_y(load, vld, xb);
        e.y     = yy;
        e.armed = m_armed;
        e.err   = m_err;
        e.cnt   = m_cnt;
        sb.push_back(e);
        if (load) begin
            m_err = !(len >= 1 && len <= MAX_LEN);
            m_armed = !m_err;
            if (!m_err) begin
                m_pat = pat;
                m_len = len;
                m_ovl = ovl;
            end
            m_hist.delete();
            m_cnt = 0;
        end else begin
            m_err = 0;
            if (m_armed && vld) begin
                if (yy && !m_ovl) begin
                    m_hist.delete();
                end else begin
                    m_hist.push_back(xb);
                    if (m_hist.size() > MAX_LEN - 1) void'(m_hist.pop_front());
                end
            end
            if (yy && m_cnt < CNT_MAX) m_cnt++;
        end
    endtask

    task automatic idle();
        step(0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) chk("scoreboard_drain", sb.size(), 0);
    endtask

    // Monitor: compares one predicted record per driven cycle, away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("y", int'(y), int'(e.y));
                chk("armed", int'(armed), int'(e.armed));
                chk("cfg_err", int'(cfg_err), int'(e.err));
`ifdef SEQ_DET_MATCH_CNT_EN
                chk("match_count", int'(match_count), e.cnt);
`endif
                if (y) hits++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [15:0] stream;
        int h0;
        stream      = 16'b0011011001010100;
        reset_n     = 1'b0;
        x           = 1'b0;
        x_valid     = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_y", int'(y), 0);
        chk("rst_armed", int'(armed), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
`ifdef SEQ_DET_MATCH_CNT_EN
        chk("rst_match_count", int'(match_count), 0);
`endif
        reset_n = 1'b1;

        // Pattern 101, overlapping: hits at t=5, 11, 13.
        h0 = hits;
        step(1, 8'b101, 3, 1, 0, 0);
        for (int t = 0; t < 16; t++) step(0, 8'h00, 0, 0, 1, stream[15 - t]);
        drain();
        chk("hits_overlap1", hits - h0, 3);
`ifdef SEQ_DET_MATCH_CNT_EN
        chk("count_overlap1", int'(match_count), 3);
`endif

        // Same stream, non-overlapping: the t=13 hit is suppressed.
        h0 = hits;
        step(1, 8'b101, 3, 0, 0, 0);
        for (int t = 0; t < 16; t++) step(0, 8'h00, 0, 0, 1, stream[15 - t]);
        drain();
        chk("hits_overlap0", hits - h0, 2);
`ifdef SEQ_DET_MATCH_CNT_EN
        chk("count_overlap0", int'(match_count), 2);
`endif

        // 8'hA5 with idle gaps presenting x=1.
        h0 = hits;
        step(1, 8'hA5, 8, 1, 0, 0);
        for (int i = 7; i >= 0; i--) begin
            bit [7:0] a5;
            a5 = 8'hA5;
            step(0, 8'h00, 0, 0, 1, a5[i]);
            step(0, 8'h00, 0, 0, 0, 1);
        end
        drain();
        chk("hits_a5_gapped", hits - h0, 1);

        // Illegal lengths disarm and pulse cfg_err; nothing matches afterwards.
        h0 = hits;
        step(1, 8'h01, 0, 1, 0, 0);
        idle();
        step(1, 8'h01, MAX_LEN + 1, 1, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 8'h00, 0, 0, 1, 1'($urandom_range(0, 1)));
        drain();
        chk("hits_illegal", hits - h0, 0);

        // Load coincident with the final bit of 101 drops it and clears history.
        step(1, 8'b101, 3, 1, 0, 0);
        step(0, 8'h00, 0, 0, 1, 1);
        step(0, 8'h00, 0, 0, 1, 0);
        step(1, 8'b101, 3, 1, 1, 1);
        step(0, 8'h00, 0, 0, 1, 1);
        step(0, 8'h00, 0, 0, 1, 0);
        step(0, 8'h00, 0, 0, 1, 1);
        step(0, 8'h00, 0, 0, 1, 0);
        drain();

        // Asynchronous reset while the completing bit is on x.
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        x_valid  = 1'b1;
        x        = 1'b1;
        #1;
        chk("y_before_async_rst", int'(y), int'(model_y(0, 1, 1)));
        reset_n = 1'b0;
        #1;
        chk("async_rst_y", int'(y), 0);
        chk("async_rst_armed", int'(armed), 0);
`ifdef SEQ_DET_MATCH_CNT_EN
        chk("async_rst_count", int'(match_count), 0);
`endif
        model_reset();
        x_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // len=1 pattern 1: every valid one matches; counter saturates.
        h0 = hits;
        step(1, 8'h01, 1, 1, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 8'h00, 0, 0, 1, 1);
        drain();
        chk("hits_len1", hits - h0, 20);
`ifdef SEQ_DET_MATCH_CNT_EN
        chk("count_saturated", int'(match_count), CNT_MAX);
`endif

        // Randomised traffic with occasional (possibly illegal) reloads.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                step(1, 8'($urandom), int'($urandom_range(0, MAX_LEN + 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
            end else begin
                step(0, 8'($urandom), 0, 0, ($urandom_range(0, 9) < 7),
                     1'($urandom_range(0, 1)));
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
